// File: rtl/simon_says_arena_if.sv
// Bus between the Simon-says arena and its players/display.
// Handshake: p_valid[i] is a press strobe with no ready. It is sampled on every rising edge; presses outside ROUND or from a locked player are dropped.
interface simon_says_arena_if #(
   parameter int N_PLAYERS = 2,
   parameter int DIR_W     = 2,
   parameter int SCORE_W   = 3
);
   logic                           start;
   logic [N_PLAYERS-1:0]           p_valid;
   logic [N_PLAYERS*DIR_W-1:0]     p_dir;
   logic [DIR_W-1:0]               random_dir;
   logic [DIR_W-1:0]               led_dir;
   logic                           led_en;
   logic [N_PLAYERS*SCORE_W-1:0]   scores;
   logic [7:0]                     round_cnt;
   logic                           game_over;
   logic [N_PLAYERS-1:0]           winner;
   logic [2:0]                     dbg_state;

   modport master (
      output start, p_valid, p_dir,
      input  random_dir, led_dir, led_en, scores, round_cnt, game_over, winner, dbg_state
   );

   modport slave (
      input  start, p_valid, p_dir,
      output random_dir, led_dir, led_en, scores, round_cnt, game_over, winner, dbg_state
   );
endinterface

// File: rtl/simon_says_arena.sv
// Multi-player Simon-says game: show a random direction, open a timed round, score presses.
// All outputs come straight from flops; dbg_state exposes the FSM for checkers.
module simon_says_arena #(
   parameter int N_PLAYERS    = 2,
   parameter int DIR_W        = 2,
   parameter int SCORE_W      = 3,
   parameter int WIN_SCORE    = 5,
   parameter int SHOW_CYCLES  = 4,
   parameter int ROUND_CYCLES = 16,
   parameter int MAX_ROUNDS   = 15,
   parameter int PENALTY      = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   simon_says_arena_if.slave bus
);
   localparam int CNT_MAX = (SHOW_CYCLES > ROUND_CYCLES) ? SHOW_CYCLES : ROUND_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SHOW  = 3'd1,
      S_ROUND = 3'd2,
      S_CHECK = 3'd3,
      S_OVER  = 3'd4
   } state_t;

   state_t                         state_q, state_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic [15:0]                    lfsr_q, lfsr_d;
   logic [N_PLAYERS-1:0]           lock_q, lock_d;
   logic [N_PLAYERS*SCORE_W-1:0]   scores_q, scores_d;
   logic [7:0]                     round_cnt_q, round_cnt_d;
   logic [DIR_W-1:0]               random_dir_q, random_dir_d;
   logic [DIR_W-1:0]               led_dir_q, led_dir_d;
   logic                           led_en_q, led_en_d;
   logic                           game_over_q, game_over_d;
   logic [N_PLAYERS-1:0]           winner_q, winner_d;

   logic [SCORE_W-1:0]             score_cur [N_PLAYERS];
   logic [DIR_W-1:0]               dir_in    [N_PLAYERS];
   logic [N_PLAYERS-1:0]           win_vec;
   logic [SCORE_W-1:0]             max_score;
   logic [7:0]                     round_next;
   logic                           game_end;

   for (genvar g = 0; g < N_PLAYERS; g++) begin : g_slice
      assign score_cur[g] = scores_q[g*SCORE_W +: SCORE_W];
      assign dir_in[g]    = bus.p_dir[g*DIR_W +: DIR_W];
      assign win_vec[g]   = (score_cur[g] >= SCORE_W'(WIN_SCORE));
   end

   assign round_next = round_cnt_q + 8'd1;
   assign game_end   = (|win_vec) || (round_next == 8'(MAX_ROUNDS));

   // Taps 16,14,13,11 -> bits 15,13,12,10; a non-zero seed keeps it out of the all-zero lockup.
   assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         lfsr_q       <= 16'hACE1;
         lock_q       <= '0;
         scores_q     <= '0;
         round_cnt_q  <= '0;
         random_dir_q <= '0;
         led_dir_q    <= '0;
         led_en_q     <= 1'b0;
         game_over_q  <= 1'b0;
         winner_q     <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         lfsr_q       <= lfsr_d;
         lock_q       <= lock_d;
         scores_q     <= scores_d;
         round_cnt_q  <= round_cnt_d;
         random_dir_q <= random_dir_d;
         led_dir_q    <= led_dir_d;
         led_en_q     <= led_en_d;
         game_over_q  <= game_over_d;
         winner_q     <= winner_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE, S_OVER: begin
            if (bus.start) begin
               state_d = S_SHOW;
               cnt_d   = '0;
            end
         end
         S_SHOW: begin
            if (cnt_q == CNT_W'(SHOW_CYCLES - 1)) begin
               state_d = S_ROUND;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_ROUND: begin
            // Locks are registered, so an all-locked round closes one cycle after the last press.
            if ((&lock_q) || (cnt_q == CNT_W'(ROUND_CYCLES - 1))) begin
               state_d = S_CHECK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_CHECK: begin
            state_d = game_end ? S_OVER : S_SHOW;
            cnt_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      scores_d     = scores_q;
      lock_d       = lock_q;
      round_cnt_d  = round_cnt_q;
      random_dir_d = random_dir_q;
      case (state_q)
         S_IDLE, S_OVER: begin
            if (bus.start) begin
               scores_d     = '0;
               lock_d       = '0;
               round_cnt_d  = '0;
               random_dir_d = lfsr_q[DIR_W-1:0];
            end
         end
         S_ROUND: begin
            for (int i = 0; i < N_PLAYERS; i++) begin
               if (bus.p_valid[i] && !lock_q[i]) begin
                  lock_d[i] = 1'b1;
                  if (dir_in[i] == random_dir_q) begin
                     if (score_cur[i] != SCORE_MAX)
                        scores_d[i*SCORE_W +: SCORE_W] = score_cur[i] + SCORE_W'(1);
                  end else if ((PENALTY != 0) && (score_cur[i] != '0)) begin
                     scores_d[i*SCORE_W +: SCORE_W] = score_cur[i] - SCORE_W'(1);
                  end
               end
            end
         end
         S_CHECK: begin
            round_cnt_d = round_next;
            lock_d      = '0;
            if (!game_end) random_dir_d = lfsr_q[DIR_W-1:0];
         end
         default: ;
      endcase

      led_en_d    = (state_d == S_SHOW);
      led_dir_d   = led_en_d ? random_dir_d : '0;
      game_over_d = (state_d == S_OVER);

      max_score = '0;
      for (int i = 0; i < N_PLAYERS; i++) begin
         if (scores_d[i*SCORE_W +: SCORE_W] > max_score) max_score = scores_d[i*SCORE_W +: SCORE_W];
      end
      winner_d = '0;
      if (game_over_d) begin
         for (int i = 0; i < N_PLAYERS; i++)
            winner_d[i] = (scores_d[i*SCORE_W +: SCORE_W] == max_score);
      end
   end

   assign bus.random_dir = random_dir_q;
   assign bus.led_dir    = led_dir_q;
   assign bus.led_en     = led_en_q;
   assign bus.scores     = scores_q;
   assign bus.round_cnt  = round_cnt_q;
   assign bus.game_over  = game_over_q;
   assign bus.winner     = winner_q;
   assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_simon_says_arena.sv
// Bench for simon_says_arena: directed game scenarios plus random presses, checked
// against a round-level game model (scores, round count, winner, phase timing).
module tb_simon_says_arena;
   localparam int NP = 2;
   localparam int DW = 2;
   localparam int SW = 3;
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SHOW  = 3'd1;
   localparam logic [2:0] ST_ROUND = 3'd2;
   localparam logic [2:0] ST_CHECK = 3'd3;
   localparam logic [2:0] ST_OVER  = 3'd4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   simon_says_arena_if #(.N_PLAYERS(NP), .DIR_W(DW), .SCORE_W(SW)) bus ();

   simon_says_arena #(
      .N_PLAYERS(NP), .DIR_W(DW), .SCORE_W(SW), .WIN_SCORE(5), .SHOW_CYCLES(4),
      .ROUND_CYCLES(16), .MAX_ROUNDS(15), .PENALTY(1)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   int checks = 0;
   int failures = 0;

   // Reference sequence: the 16-bit Fibonacci LFSR stepped once per clock from its seed.
   logic [15:0] mdl_lfsr;
   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      logic [15:0] masked;
      masked = v & 16'hB400;
      return {v[14:0], ^masked};
   endfunction
   always @(posedge clk) mdl_lfsr <= !rst_n ? 16'hACE1 : lfsr_step(mdl_lfsr);

   int            m_score [NP];
   int            m_rounds;
   logic [DW-1:0] exp_dir;
   bit            game_done;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic int apply_press(input int s, input bit ok);
      if (ok) return (s < 7) ? s + 1 : s;
      return (s > 0) ? s - 1 : 0;
   endfunction

   function automatic logic [NP*SW-1:0] mdl_scores();
      logic [NP*SW-1:0] r;
      for (int i = 0; i < NP; i++) r[i*SW +: SW] = SW'(m_score[i]);
      return r;
   endfunction

   function automatic logic [NP-1:0] mdl_winner();
      int mx;
      logic [NP-1:0] w;
      mx = 0;
      for (int i = 0; i < NP; i++) if (m_score[i] > mx) mx = m_score[i];
      for (int i = 0; i < NP; i++) w[i] = (m_score[i] == mx);
      return w;
   endfunction

   function automatic logic [DW-1:0] pick_dir(input bit ok);
      logic [DW-1:0] off;
      off = DW'($urandom_range(1, 3));
      return ok ? exp_dir : exp_dir + off;
   endfunction

   task automatic start_game();
      bus.start   = 1'b1;
      bus.p_valid = '0;
      exp_dir     = mdl_lfsr[DW-1:0];
      for (int i = 0; i < NP; i++) m_score[i] = 0;
      m_rounds  = 0;
      game_done = 1'b0;
      tick();
      bus.start = 1'b0;
   endtask

   // Plays one SHOW+ROUND+CHECK. pcX = round cycle of player X's press (-1 = none);
   // pc0b is a second P0 press that must be swallowed by the lock.
   task automatic play_round(input int pc0, input bit ok0, input int pc1, input bit ok1,
                             input int pc0b, input bit ok0b);
      bit lk0, lk1, ending, hit0, hit1, g0, over;
      logic [DW-1:0] d0, d1, nxt;
      int r;
      for (int s = 0; s < 4; s++) begin
         chk("show_state", bus.dbg_state, ST_SHOW);
         chk("show_led_en", bus.led_en, 1);
         chk("show_led_dir", bus.led_dir, exp_dir);
         chk("show_random_dir", bus.random_dir, exp_dir);
         chk("show_scores", bus.scores, mdl_scores());
         chk("show_winner", bus.winner, 0);
         bus.p_valid = NP'($urandom_range(0, 3));
         bus.p_dir   = (NP*DW)'($urandom);
         bus.start   = 1'($urandom_range(0, 1));
         tick();
      end
      lk0 = 1'b0; lk1 = 1'b0; r = 0; ending = 1'b0;
      while (!ending) begin
         chk("round_state", bus.dbg_state, ST_ROUND);
         chk("round_led_en", bus.led_en, 0);
         chk("round_led_dir", bus.led_dir, 0);
         chk("round_random_dir", bus.random_dir, exp_dir);
         chk("round_scores", bus.scores, mdl_scores());
         ending = (lk0 && lk1) || (r == 15);
         hit0 = (r == pc0) || (r == pc0b);
         g0   = (r == pc0) ? ok0 : ok0b;
         hit1 = (r == pc1);
         d0 = hit0 ? pick_dir(g0) : DW'($urandom);
         d1 = hit1 ? pick_dir(ok1) : DW'($urandom);
         bus.p_valid = {hit1, hit0};
         bus.p_dir   = {d1, d0};
         bus.start   = 1'($urandom_range(0, 1));
         if (hit0 && !lk0) begin lk0 = 1'b1; m_score[0] = apply_press(m_score[0], g0); end
         if (hit1 && !lk1) begin lk1 = 1'b1; m_score[1] = apply_press(m_score[1], ok1); end
         tick();
         r++;
      end
      chk("check_state", bus.dbg_state, ST_CHECK);
      chk("check_scores", bus.scores, mdl_scores());
      chk("check_round_cnt", bus.round_cnt, m_rounds);
      nxt = mdl_lfsr[DW-1:0];
      m_rounds++;
      over = (m_score[0] >= 5) || (m_score[1] >= 5) || (m_rounds == 15);
      bus.p_valid = NP'($urandom_range(0, 3));
      bus.start   = 1'($urandom_range(0, 1));
      tick();
      bus.start = 1'b0;
      chk("post_check_round_cnt", bus.round_cnt, m_rounds);
      if (over) begin
         game_done = 1'b1;
         for (int k = 0; k < 3; k++) begin
            chk("over_state", bus.dbg_state, ST_OVER);
            chk("over_game_over", bus.game_over, 1);
            chk("over_winner", bus.winner, mdl_winner());
            chk("over_scores", bus.scores, mdl_scores());
            chk("over_led_en", bus.led_en, 0);
            bus.p_valid = NP'($urandom_range(0, 3));
            bus.p_dir   = (NP*DW)'($urandom);
            tick();
         end
         bus.p_valid = '0;
      end else begin
         exp_dir = nxt;
         chk("next_game_over", bus.game_over, 0);
      end
   endtask

   initial begin
      int v, pc0, pc1, pc0b, guard;
      bus.start = 1'b0; bus.p_valid = '0; bus.p_dir = '0;
      rst_n = 1'b0;
      repeat (2) tick();
      chk("rst_state", bus.dbg_state, ST_IDLE);
      chk("rst_random_dir", bus.random_dir, 0);
      chk("rst_led_dir", bus.led_dir, 0);
      chk("rst_led_en", bus.led_en, 0);
      chk("rst_scores", bus.scores, 0);
      chk("rst_round_cnt", bus.round_cnt, 0);
      chk("rst_game_over", bus.game_over, 0);
      chk("rst_winner", bus.winner, 0);
      rst_n = 1'b1;
      bus.p_valid = 2'b11;
      tick();
      bus.p_valid = '0;
      tick();
      chk("idle_state", bus.dbg_state, ST_IDLE);
      chk("idle_scores", bus.scores, 0);

      // Simultaneous correct P0 / wrong P1, then wrong-then-correct P0 with P1 silent.
      start_game();
      play_round(2, 1'b1, 2, 1'b0, -1, 1'b0);
      chk("score_p0_one_p1_zero", bus.scores, 6'b000_001);
      chk("round_cnt_one", bus.round_cnt, 1);
      play_round(1, 1'b0, -1, 1'b0, 3, 1'b1);
      chk("lock_single_decrement", bus.scores, 6'b000_000);

      // Random play until the game ends by win or round limit.
      guard = 0;
      while (!game_done && guard < 20) begin
         v = $urandom_range(0, 17); pc0 = (v > 15) ? -1 : v;
         v = $urandom_range(0, 17); pc1 = (v > 15) ? -1 : v;
         pc0b = (pc0 < 0) ? -1 : pc0 + $urandom_range(1, 4);
         play_round(pc0, 1'($urandom_range(0, 1)), pc1, 1'($urandom_range(0, 1)),
                    pc0b, 1'($urandom_range(0, 1)));
         guard++;
      end
      chk("random_game_ended", game_done, 1);

      // Restart from OVER: P0 always correct, P1 silent -> P0 wins after 5 rounds.
      start_game();
      for (int k = 0; k < 5; k++) play_round($urandom_range(0, 15), 1'b1, -1, 1'b0, -1, 1'b0);
      chk("win_game_over", bus.game_over, 1);
      chk("win_winner", bus.winner, 2'b01);
      chk("win_scores", bus.scores, 6'b000_101);
      chk("win_round_cnt", bus.round_cnt, 5);

      // Nobody presses: round limit reached with a two-way tie at zero.
      start_game();
      for (int k = 0; k < 15; k++) play_round(-1, 1'b0, -1, 1'b0, -1, 1'b0);
      chk("timeout_game_over", bus.game_over, 1);
      chk("timeout_round_cnt", bus.round_cnt, 15);
      chk("timeout_winner", bus.winner, 2'b11);
      chk("timeout_scores", bus.scores, 0);

      // Reset lands on the same edge as a correct press.
      start_game();
      repeat (6) tick();
      chk("midrst_in_round", bus.dbg_state, ST_ROUND);
      bus.p_valid = 2'b01;
      bus.p_dir   = {2'b00, exp_dir};
      rst_n       = 1'b0;
      tick();
      bus.p_valid = '0;
      chk("midrst_scores", bus.scores, 0);
      chk("midrst_state", bus.dbg_state, ST_IDLE);
      chk("midrst_game_over", bus.game_over, 0);
      chk("midrst_led_en", bus.led_en, 0);
      chk("midrst_random_dir", bus.random_dir, 0);
      rst_n = 1'b1;
      tick();

      // Fresh game after reset: both players correct in the first round cycle.
      start_game();
      play_round(0, 1'b1, 0, 1'b1, -1, 1'b0);
      chk("post_rst_scores", bus.scores, 6'b001_001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/simon_says_arena.md
SIMON_SAYS_ARENA -- requirements
Module: simon_says_arena

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning):
  N_PLAYERS 2, number of player channels (2..8)
  DIR_W 2, direction code width
  SCORE_W 3, per-player score width
  WIN_SCORE 5, score that ends the game (< 2^SCORE_W)
  SHOW_CYCLES 4, cycles the direction is displayed before a round opens
  ROUND_CYCLES 16, cycles a round stays open
  MAX_ROUNDS 15, round limit (fits in 8 bits)
  PENALTY 1, 1 = a wrong press decrements the score, 0 = no decrement
REQ-002 The module SHALL have these ports (name, direction, width, meaning):
  clk  in  1  single clock; all logic on the rising edge
  rst_n  in  1  synchronous, active-low reset
  start  in  1  one-cycle pulse; starts a game from IDLE or OVER
  p_valid  in  N_PLAYERS  per-player press strobe
  p_dir  in  N_PLAYERS*DIR_W  per-player pressed direction; player i at bits [i*DIR_W +: DIR_W]
  random_dir  out  DIR_W  current round target
  led_dir  out  DIR_W  displayed direction
  led_en  out  1  display active
  scores  out  N_PLAYERS*SCORE_W  packed scores, same slicing as p_dir
  round_cnt  out  8  rounds completed
  game_over  out  1  game finished
  winner  out  N_PLAYERS  one-hot/multi-hot mask of the top-scoring players

Function
REQ-003 The FSM SHALL have the states IDLE, SHOW, ROUND, CHECK and OVER.
REQ-004 A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) SHALL advance every cycle, including IDLE, and SHALL never hold zero.
REQ-005 IDLE, on start=1: scores, round_cnt and locks SHALL clear, random_dir SHALL load lfsr[DIR_W-1:0], and the FSM SHALL go to SHOW.
REQ-006 SHOW SHALL last exactly SHOW_CYCLES cycles, with led_en=1 and led_dir=random_dir, then go to ROUND; presses during SHOW SHALL be ignored.
REQ-007 ROUND SHALL last at most ROUND_CYCLES cycles, with led_en=0 and led_dir=0.
REQ-008 ROUND SHALL end early, in the cycle after the last unlocked player locks.
REQ-009 In ROUND, a press by an unlocked player i (p_valid[i]=1) SHALL lock that player for the rest of the round; later presses by that player SHALL be ignored.
REQ-010 A correct press (p_dir slice = random_dir) SHALL increment score i on the next edge, saturating at 2^SCORE_W-1.
REQ-011 A wrong press SHALL decrement score i when PENALTY=1, saturating at 0, and SHALL leave it unchanged when PENALTY=0.
REQ-012 Simultaneous presses by several players in one cycle SHALL each be processed independently in that cycle.
REQ-013 CHECK SHALL last 1 cycle and SHALL: increment round_cnt and clear all locks.
REQ-014 CHECK SHALL then go to OVER if any score >= WIN_SCORE or round_cnt (after increment) = MAX_ROUNDS; otherwise it SHALL load a new random_dir from the LFSR and go to SHOW.
REQ-015 OVER SHALL hold game_over=1 and the scores frozen.
REQ-016 In OVER, winner SHALL have bit i set iff score i equals the maximum score, so ties set multiple bits; winner SHALL be 0 outside OVER.
REQ-017 In OVER, start=1 SHALL behave as in IDLE (REQ-005).
REQ-018 start SHALL be ignored in SHOW, ROUND and CHECK.
REQ-019 All outputs SHALL be registered.

Reset
REQ-020 When rst_n=0 at a clock edge, the FSM SHALL go to IDLE.
REQ-021 Reset SHALL zero scores, round_cnt, random_dir, led_dir, led_en, game_over, winner and all locks.
REQ-022 Reset SHALL reload the LFSR with the seed.
REQ-023 Reset asserted mid-round SHALL abort the round, with no score update in that cycle.

Verification
REQ-024 Check reset and start: rst_n low for 2 cycles -> all outputs 0 and FSM in IDLE; start pulse -> led_en=1 for exactly 4 cycles with led_dir=random_dir.
REQ-025 Check scoring: in ROUND, P0 presses correct and P1 presses wrong in the same cycle -> next cycle scores P0=1, P1=0 (saturated); both locked -> CHECK the following cycle; round_cnt=1.
REQ-026 Check the lock: P0 presses wrong, then correct 2 cycles later in the same round -> P0 score decrements once only; the round runs the full 16 cycles if P1 never presses.
REQ-027 Check the win: P0 correct for 5 rounds, P1 silent -> game_over=1 after the 5th CHECK, winner=2'b01, scores={0,5}.
REQ-028 Check tie and timeout: no presses for 15 rounds -> game_over=1, round_cnt=15, winner=2'b11.
REQ-029 Check reset mid-round: rst_n low during ROUND at the cycle of a correct press -> score stays 0, IDLE, game_over=0.
